i_decode: RTL and testbench

- Instruction-decode stage of the 5-stage MIPS pipeline, directly downstream of the fetch stage.
- Consumes IF_ID_instr / IF_ID_npc and decodes opcode into WB/M/EX control groups.
- Reads two operands from an internal 32x32 register file and sign-extends the immediate.
- Registers everything into the ID/EX pipeline register. Accepts the MEM/WB write-back port for register-file writes.

---
 rtl/mips_pkg.sv | 83 ++++++++
 rtl/i_decode_reg_file.sv | 68 ++++++
 rtl/i_decode.sv | 117 +++++++++++
 tb/tb_i_decode.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// -----------------------------------------------------------------------------
// mips_pkg
// Shared definitions for the MIPS pipeline decode stage:
//   - primary opcode constants
//   - control-group widths and ALUOp encodings
//   - packed control structs for the WB / M / EX groups
//   - decode_op(): maps a primary opcode to its control bundle
// Configuration macro used elsewhere in this slice: REGFILE_BYPASS_EN
// (write-through bypass in reg_file).
// -----------------------------------------------------------------------------
package mips_pkg;

   localparam int WB_W = 2;
   localparam int M_W  = 3;
   localparam int EX_W = 4;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;
   localparam logic [5:0] OP_BEQ   = 6'h04;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

   // {RegWrite, MemtoReg}
   typedef struct packed {
      logic reg_write;
      logic mem_to_reg;
   } wb_ctl_t;

   // {Branch, MemRead, MemWrite}
   typedef struct packed {
      logic branch;
      logic mem_read;
      logic mem_write;
   } m_ctl_t;

   // {RegDst, ALUOp[1:0], ALUSrc}
   typedef struct packed {
      logic       reg_dst;
      logic [1:0] alu_op;
      logic       alu_src;
   } ex_ctl_t;

   typedef struct packed {
      wb_ctl_t wb;
      m_ctl_t  m;
      ex_ctl_t ex;
      logic    illegal;
   } ctl_t;

   // Unsupported opcodes produce an all-zero bundle so a stray instruction
   // can never write a register or touch memory; only illegal is raised.
   // The all-zero word (sll $0,$0,0 / nop) has opcode 0 and lands in R-type.
   function automatic ctl_t decode_op(input logic [5:0] op);
      ctl_t c;
      c = '0;
      case (op)
         OP_RTYPE: begin
            c.wb = '{reg_write: 1'b1, mem_to_reg: 1'b0};
            c.ex = '{reg_dst: 1'b1, alu_op: ALUOP_FUNCT, alu_src: 1'b0};
         end
         OP_LW: begin
            c.wb = '{reg_write: 1'b1, mem_to_reg: 1'b1};
            c.m  = '{branch: 1'b0, mem_read: 1'b1, mem_write: 1'b0};
            c.ex = '{reg_dst: 1'b0, alu_op: ALUOP_ADD, alu_src: 1'b1};
         end
         OP_SW: begin
            // MemtoReg is a don't-care for stores; drive it low.
            c.m  = '{branch: 1'b0, mem_read: 1'b0, mem_write: 1'b1};
            c.ex = '{reg_dst: 1'b0, alu_op: ALUOP_ADD, alu_src: 1'b1};
         end
         OP_BEQ: begin
            c.m  = '{branch: 1'b1, mem_read: 1'b0, mem_write: 1'b0};
            c.ex = '{reg_dst: 1'b0, alu_op: ALUOP_SUB, alu_src: 1'b0};
         end
         default: c.illegal = 1'b1;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/i_decode_reg_file.sv
// -----------------------------------------------------------------------------
// reg_file
// Architectural register file: two combinational read ports, one synchronous
// write port, asynchronous active-high reset clearing every entry.
// Entry 0 is hardwired to zero: writes to it are dropped and reads return 0.
//
// Ports:
//   clk, rst        clock / async active-high reset
//   raddr1, rdata1  read port 1 (rs)
//   raddr2, rdata2  read port 2 (rt)
//   we, waddr, wdata  write port (MEM/WB write-back)
//
// Macro REGFILE_BYPASS_EN: when defined, a read of the register being
// written in the same cycle returns the incoming write data. When undefined
// the stored (old) contents are returned.
// -----------------------------------------------------------------------------
module reg_file
   import mips_pkg::*;
#(
   parameter int REG_COUNT = 32,
   parameter int DATA_W    = 32,
   parameter int AW        = $clog2(REG_COUNT)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [AW-1:0]     raddr1,
   input  logic [AW-1:0]     raddr2,
   output logic [DATA_W-1:0] rdata1,
   output logic [DATA_W-1:0] rdata2,
   input  logic              we,
   input  logic [AW-1:0]     waddr,
   input  logic [DATA_W-1:0] wdata
);

   logic [DATA_W-1:0] regs [REG_COUNT];
   logic              wr_ok;

   assign wr_ok = we && (waddr != '0);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < REG_COUNT; i++) regs[i] <= '0;
      end else if (wr_ok) begin
         regs[waddr] <= wdata;
      end
   end

`ifdef REGFILE_BYPASS_EN
   // Write-through: the word landing this edge is visible to the reader now,
   // so ID/EX captures the fresh value instead of the stale one.
   always_comb begin
      rdata1 = '0;
      rdata2 = '0;
      if (raddr1 != '0) rdata1 = (wr_ok && waddr == raddr1) ? wdata : regs[raddr1];
      if (raddr2 != '0) rdata2 = (wr_ok && waddr == raddr2) ? wdata : regs[raddr2];
   end
`else
   // Stored contents only; a same-cycle write/read returns the old value and
   // the hazard unit is responsible for that case.
   always_comb begin
      rdata1 = '0;
      rdata2 = '0;
      if (raddr1 != '0) rdata1 = regs[raddr1];
      if (raddr2 != '0) rdata2 = regs[raddr2];
   end
`endif

endmodule

// File: rtl/i_decode.sv
// -----------------------------------------------------------------------------
// i_decode
// Instruction-decode stage of the 5-stage MIPS pipeline. Decodes the opcode
// into WB/M/EX control groups, reads rs/rt from the register file, sign-
// extends the immediate and registers all of it into the ID/EX register.
// The MEM/WB write-back port writes the register file every cycle,
// independent of stall/flush.
//
// Ports:
//   clk, rst                 clock / async active-high reset
//   IF_ID_instr, IF_ID_npc   instruction and PC+4 from IF/ID
//   ID_stall                 hold ID/EX contents
//   ID_flush                 load a bubble (all zero) into ID/EX
//   MEM_WB_RegWrite/WriteReg/WriteData  register-file write-back
//   ID_EX_*                  registered decode results (1-cycle latency)
//
// Macro REGFILE_BYPASS_EN: enables write-through bypass in reg_file.
// -----------------------------------------------------------------------------
module i_decode
   import mips_pkg::*;
#(
   parameter int REG_COUNT = 32,
   parameter int DATA_W    = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [31:0]       IF_ID_instr,
   input  logic [31:0]       IF_ID_npc,
   input  logic              ID_stall,
   input  logic              ID_flush,
   input  logic              MEM_WB_RegWrite,
   input  logic [4:0]        MEM_WB_WriteReg,
   input  logic [DATA_W-1:0] MEM_WB_WriteData,
   output logic [WB_W-1:0]   ID_EX_wb,
   output logic [M_W-1:0]    ID_EX_m,
   output logic [EX_W-1:0]   ID_EX_ex,
   output logic [31:0]       ID_EX_npc,
   output logic [DATA_W-1:0] ID_EX_readdat1,
   output logic [DATA_W-1:0] ID_EX_readdat2,
   output logic [DATA_W-1:0] ID_EX_sign_ext,
   output logic [4:0]        ID_EX_instr_2016,
   output logic [4:0]        ID_EX_instr_1511,
   output logic              ID_EX_illegal
);

   logic [5:0]        opcode;
   logic [4:0]        rs, rt, rd;
   logic [15:0]       imm;
   ctl_t              ctl;
   logic [DATA_W-1:0] rdata1, rdata2;
   logic [DATA_W-1:0] sext;

   assign opcode = IF_ID_instr[31:26];
   assign rs     = IF_ID_instr[25:21];
   assign rt     = IF_ID_instr[20:16];
   assign rd     = IF_ID_instr[15:11];
   assign imm    = IF_ID_instr[15:0];

   assign ctl  = decode_op(opcode);
   assign sext = {{(DATA_W-16){imm[15]}}, imm};

   reg_file #(
      .REG_COUNT (REG_COUNT),
      .DATA_W    (DATA_W),
      .AW        (5)
   ) u_rf (
      .clk    (clk),
      .rst    (rst),
      .raddr1 (rs),
      .raddr2 (rt),
      .rdata1 (rdata1),
      .rdata2 (rdata2),
      .we     (MEM_WB_RegWrite),
      .waddr  (MEM_WB_WriteReg),
      .wdata  (MEM_WB_WriteData)
   );

   // ID/EX pipeline register. Flush wins over stall so a stalled slot can
   // still be squashed; a bubble is all-zero, hence side-effect free.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ID_EX_wb         <= '0;
         ID_EX_m          <= '0;
         ID_EX_ex         <= '0;
         ID_EX_npc        <= '0;
         ID_EX_readdat1   <= '0;
         ID_EX_readdat2   <= '0;
         ID_EX_sign_ext   <= '0;
         ID_EX_instr_2016 <= '0;
         ID_EX_instr_1511 <= '0;
         ID_EX_illegal    <= 1'b0;
      end else if (ID_flush) begin
         ID_EX_wb         <= '0;
         ID_EX_m          <= '0;
         ID_EX_ex         <= '0;
         ID_EX_npc        <= '0;
         ID_EX_readdat1   <= '0;
         ID_EX_readdat2   <= '0;
         ID_EX_sign_ext   <= '0;
         ID_EX_instr_2016 <= '0;
         ID_EX_instr_1511 <= '0;
         ID_EX_illegal    <= 1'b0;
      end else if (!ID_stall) begin
         ID_EX_wb         <= ctl.wb;
         ID_EX_m          <= ctl.m;
         ID_EX_ex         <= ctl.ex;
         ID_EX_npc        <= IF_ID_npc;
         ID_EX_readdat1   <= rdata1;
         ID_EX_readdat2   <= rdata2;
         ID_EX_sign_ext   <= sext;
         ID_EX_instr_2016 <= rt;
         ID_EX_instr_1511 <= rd;
         ID_EX_illegal    <= ctl.illegal;
      end
   end

endmodule

// File: tb/tb_i_decode.sv
// -----------------------------------------------------------------------------
// tb_i_decode
// Self-checking bench for i_decode: a directed vector table, a mid-operation
// reset sequence, then randomized traffic checked against a behavioural model
// (array register file + opcode table). Honours REGFILE_BYPASS_EN.
// -----------------------------------------------------------------------------
module tb_i_decode;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] instr, npc;
   logic        stall, flush;
   logic        we;
   logic [4:0]  wreg;
   logic [31:0] wdata;

   logic [1:0]  o_wb;
   logic [2:0]  o_m;
   logic [3:0]  o_ex;
   logic [31:0] o_npc, o_rd1, o_rd2, o_sx;
   logic [4:0]  o_rt, o_rd;
   logic        o_ill;

   always #5 clk = ~clk;

   i_decode dut (
      .clk              (clk),
      .rst              (rst),
      .IF_ID_instr      (instr),
      .IF_ID_npc        (npc),
      .ID_stall         (stall),
      .ID_flush         (flush),
      .MEM_WB_RegWrite  (we),
      .MEM_WB_WriteReg  (wreg),
      .MEM_WB_WriteData (wdata),
      .ID_EX_wb         (o_wb),
      .ID_EX_m          (o_m),
      .ID_EX_ex         (o_ex),
      .ID_EX_npc        (o_npc),
      .ID_EX_readdat1   (o_rd1),
      .ID_EX_readdat2   (o_rd2),
      .ID_EX_sign_ext   (o_sx),
      .ID_EX_instr_2016 (o_rt),
      .ID_EX_instr_1511 (o_rd),
      .ID_EX_illegal    (o_ill)
   );

`ifdef REGFILE_BYPASS_EN
   localparam logic [31:0] BYP7 = 32'h55;
   localparam bit          BYPASS = 1'b1;
`else
   localparam logic [31:0] BYP7 = 32'h0;
   localparam bit          BYPASS = 1'b0;
`endif

   typedef struct packed {
      logic [1:0]  wb;
      logic [2:0]  m;
      logic [3:0]  ex;
      logic [31:0] npc;
      logic [31:0] rd1;
      logic [31:0] rd2;
      logic [31:0] sx;
      logic [4:0]  rt;
      logic [4:0]  rd;
      logic        ill;
   } out_t;

   typedef struct {
      logic [31:0] instr;
      logic [31:0] npc;
      logic        stall;
      logic        flush;
      logic        we;
      logic [4:0]  wreg;
      logic [31:0] wdata;
      out_t        exp;
   } vec_t;

   int checks = 0;
   int errors = 0;

   logic [31:0] mrf [32];
   out_t        mexp;

   function automatic out_t mo(logic [1:0] wb, logic [2:0] m, logic [3:0] ex,
                               logic [31:0] n, logic [31:0] r1, logic [31:0] r2,
                               logic [31:0] sx, logic [4:0] rt, logic [4:0] rd,
                               logic ill);
      out_t o;
      o.wb = wb; o.m = m; o.ex = ex; o.npc = n; o.rd1 = r1; o.rd2 = r2;
      o.sx = sx; o.rt = rt; o.rd = rd; o.ill = ill;
      return o;
   endfunction

   function automatic vec_t mv(logic [31:0] i, logic [31:0] n, logic s, logic f,
                               logic w, logic [4:0] wr, logic [31:0] wd, out_t e);
      vec_t v;
      v.instr = i; v.npc = n; v.stall = s; v.flush = f;
      v.we = w; v.wreg = wr; v.wdata = wd; v.exp = e;
      return v;
   endfunction

   // Reference read: $0 is zero; with bypass a matching write is visible now.
   function automatic logic [31:0] mread(logic [4:0] a);
      if (a == 5'd0) return 32'h0;
      if (BYPASS && we && wreg != 5'd0 && wreg == a) return wdata;
      return mrf[a];
   endfunction

   function automatic out_t model_next();
      out_t o;
      o = '0;
      case (instr[31:26])
         6'h00:   begin o.wb = 2'b10; o.m = 3'b000; o.ex = 4'b1100; end
         6'h23:   begin o.wb = 2'b11; o.m = 3'b010; o.ex = 4'b0001; end
         6'h2B:   begin o.wb = 2'b00; o.m = 3'b001; o.ex = 4'b0001; end
         6'h04:   begin o.wb = 2'b00; o.m = 3'b100; o.ex = 4'b0010; end
         default: o.ill = 1'b1;
      endcase
      o.npc = npc;
      o.rd1 = mread(instr[25:21]);
      o.rd2 = mread(instr[20:16]);
      o.sx  = {{16{instr[15]}}, instr[15:0]};
      o.rt  = instr[20:16];
      o.rd  = instr[15:11];
      return o;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 32; i++) mrf[i] = 32'h0;
      mexp = '0;
   endtask

   task automatic drive(vec_t v);
      instr = v.instr; npc = v.npc; stall = v.stall; flush = v.flush;
      we = v.we; wreg = v.wreg; wdata = v.wdata;
   endtask

   // Advance one clock: update model from the inputs seen at the edge, then
   // return 1 time unit after the edge so outputs are settled.
   task automatic tick();
      out_t nxt;
      nxt = model_next();
      if (flush)       mexp = '0;
      else if (!stall) mexp = nxt;
      if (we && wreg != 5'd0) mrf[wreg] = wdata;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic compare(string tag, out_t e);
      chk({tag, ".wb"},   {30'd0, o_wb},  {30'd0, e.wb});
      chk({tag, ".m"},    {29'd0, o_m},   {29'd0, e.m});
      chk({tag, ".ex"},   {28'd0, o_ex},  {28'd0, e.ex});
      chk({tag, ".npc"},  o_npc,          e.npc);
      chk({tag, ".rd1"},  o_rd1,          e.rd1);
      chk({tag, ".rd2"},  o_rd2,          e.rd2);
      chk({tag, ".sx"},   o_sx,           e.sx);
      chk({tag, ".rt"},   {27'd0, o_rt},  {27'd0, e.rt});
      chk({tag, ".rd"},   {27'd0, o_rd},  {27'd0, e.rd});
      chk({tag, ".ill"},  {31'd0, o_ill}, {31'd0, e.ill});
   endtask

   vec_t tbl [15];
   out_t z;

   initial begin
      z = '0;
      // Directed table (register-file state carries from row to row).
      tbl[0]  = mv(32'h0000_0000, 32'h100, 0, 0, 1, 5'd5, 32'h1234,
                   mo(2'b10, 3'b000, 4'b1100, 32'h100, 0, 0, 0, 0, 0, 0));
      tbl[1]  = mv(32'h00A6_3020, 32'h104, 0, 0, 0, 0, 0,
                   mo(2'b10, 3'b000, 4'b1100, 32'h104, 32'h1234, 0, 32'h3020, 6, 6, 0));
      tbl[2]  = mv(32'h8C62_FFFC, 32'h108, 0, 0, 0, 0, 0,
                   mo(2'b11, 3'b010, 4'b0001, 32'h108, 0, 0, 32'hFFFF_FFFC, 2, 31, 0));
      tbl[3]  = mv(32'h0000_0000, 32'h10C, 0, 0, 1, 5'd0, 32'hDEAD,
                   mo(2'b10, 3'b000, 4'b1100, 32'h10C, 0, 0, 0, 0, 0, 0));
      tbl[4]  = mv(32'h0000_0000, 32'h110, 0, 0, 0, 0, 0,
                   mo(2'b10, 3'b000, 4'b1100, 32'h110, 0, 0, 0, 0, 0, 0));
      tbl[5]  = mv(32'h00E0_4020, 32'h114, 0, 0, 1, 5'd7, 32'h55,
                   mo(2'b10, 3'b000, 4'b1100, 32'h114, BYP7, 0, 32'h4020, 0, 8, 0));
      tbl[6]  = mv(32'h00E0_4020, 32'h118, 0, 0, 0, 0, 0,
                   mo(2'b10, 3'b000, 4'b1100, 32'h118, 32'h55, 0, 32'h4020, 0, 8, 0));
      tbl[7]  = mv(32'hFC00_0000, 32'h11C, 0, 0, 0, 0, 0,
                   mo(2'b00, 3'b000, 4'b0000, 32'h11C, 0, 0, 0, 0, 0, 1));
      tbl[8]  = mv(32'hAC07_0008, 32'h120, 0, 0, 0, 0, 0,
                   mo(2'b00, 3'b001, 4'b0001, 32'h120, 0, 32'h55, 8, 7, 0, 0));
      tbl[9]  = mv(32'h10E7_0003, 32'h124, 0, 0, 0, 0, 0,
                   mo(2'b00, 3'b100, 4'b0010, 32'h124, 32'h55, 32'h55, 3, 7, 0, 0));
      tbl[10] = mv(32'h8C62_FFFC, 32'h128, 1, 0, 0, 0, 0,
                   mo(2'b00, 3'b100, 4'b0010, 32'h124, 32'h55, 32'h55, 3, 7, 0, 0));
      tbl[11] = mv(32'h00A6_3020, 32'h12C, 1, 0, 1, 5'd9, 32'h99,
                   mo(2'b00, 3'b100, 4'b0010, 32'h124, 32'h55, 32'h55, 3, 7, 0, 0));
      tbl[12] = mv(32'hAC07_0008, 32'h130, 1, 1, 0, 0, 0, z);
      tbl[13] = mv(32'h0120_0000, 32'h134, 0, 0, 0, 0, 0,
                   mo(2'b10, 3'b000, 4'b1100, 32'h134, 32'h99, 0, 0, 0, 0, 0));
      tbl[14] = mv(32'h8C62_FFFC, 32'h138, 0, 1, 1, 5'd10, 32'hAA, z);

      // Reset with busy inputs: outputs must sit at zero.
      rst = 1'b1;
      drive(mv(32'h00A6_3020, 32'h200, 0, 0, 1, 5'd5, 32'h777, z));
      model_reset();
      #12;
      compare("reset", z);
      rst = 1'b0;

      for (int i = 0; i < 15; i++) begin
         drive(tbl[i]);
         tick();
         compare($sformatf("vec%0d", i), tbl[i].exp);
      end

      // Mid-operation async reset: load add, then reset between edges.
      drive(mv(32'h0000_0000, 32'h300, 0, 0, 1, 5'd5, 32'h1234, z));
      tick();
      drive(mv(32'h00A6_3020, 32'h304, 0, 0, 0, 0, 0, z));
      tick();
      chk("pre_rst.rd1", o_rd1, 32'h1234);
      stall = 1'b1;
      #1 rst = 1'b1;
      #1 compare("async_rst", z);
      #1 rst = 1'b0;
      model_reset();
      stall = 1'b0;
      tick();
      chk("post_rst.r5", o_rd1, 32'h0);
      compare("post_rst", mexp);

      // Randomized traffic against the model.
      for (int n = 0; n < 400; n++) begin
         logic [5:0] op;
         case ($urandom_range(0, 4))
            0: op = 6'h00;
            1: op = 6'h23;
            2: op = 6'h2B;
            3: op = 6'h04;
            default: begin
               op = 6'($urandom_range(0, 63));
               while (op == 6'h00 || op == 6'h23 || op == 6'h2B ||
                      op == 6'h04 || op == 6'h20)
                  op = 6'($urandom_range(0, 63));
            end
         endcase
         instr = {op, 26'($urandom)};
         npc   = $urandom;
         stall = ($urandom_range(0, 4) == 0);
         flush = ($urandom_range(0, 7) == 0);
         we    = $urandom_range(0, 1) == 1;
         wreg  = ($urandom_range(0, 2) == 0) ? instr[25:21] : 5'($urandom);
         wdata = $urandom;
         tick();
         compare($sformatf("rnd%0d", n), mexp);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
